// File: rtl/pipeline_stall_controller_pkg.sv
// Shared constants, state encoding and hold/bubble mask helpers for the
// pipeline stall controller. Optional feature macro: PIPELINE_STALL_COUNTER_EN.
package pipeline_stall_controller_pkg;

  // Level of the reset input that means "in reset".
  localparam logic RESET_ENABLE = 1'b1;

  // Stall-request stage indices, ordered by pipeline depth.
  localparam int STAGE_IF  = 0;
  localparam int STAGE_ID  = 1;
  localparam int STAGE_EX  = 2;
  localparam int STAGE_MEM = 3;

  // Latch bit positions: [0]=pc [1]=if_id [2]=id_ex [3]=ex_mem [4]=mem_wb.
  localparam int NUM_LATCHES = 5;
  typedef logic [NUM_LATCHES-1:0] latch_vec_t;

  // A flush keeps pc writable (redirect target) and zeroes every pipeline latch.
  localparam latch_vec_t FLUSH_BUBBLE = 5'b11110;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_BUSY = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_e;

  // depth = highest stalled stage + 1 (0 means nothing stalled).
  // Every latch upstream of and including the stalled stage holds.
  function automatic latch_vec_t stall_mask(input logic [2:0] depth);
    latch_vec_t m;
    m = '0;
    for (int i = 0; i < NUM_LATCHES; i++) begin
      m[i] = (i < int'(depth));
    end
    return m;
  endfunction

  // The latch just downstream of the stalled stage loads a bubble.
  function automatic latch_vec_t bubble_mask(input logic [2:0] depth);
    latch_vec_t m;
    m = '0;
    if ((depth != 3'd0) && (int'(depth) < NUM_LATCHES)) begin
      m[depth] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Request/response bundle between the datapath and the stall controller.
// Optional feature macro (handled in the top): PIPELINE_STALL_COUNTER_EN.
interface pipeline_stall_controller_if #(
  parameter int CYCLE_WIDTH = 6
);
  import pipeline_stall_controller_pkg::*;

  logic                   if_stall_request;
  logic                   id_stall_request;
  logic                   mem_stall_request;
  logic                   flush_request;
  logic                   ex_multicycle_start;
  logic [CYCLE_WIDTH-1:0] ex_multicycle_cycles;
  latch_vec_t             stall;
  latch_vec_t             bubble;
  logic                   ex_multicycle_done;
  logic                   ex_busy;

  // Datapath side: raises requests, consumes hold/bubble controls.
  modport master (
    output if_stall_request, id_stall_request, mem_stall_request, flush_request,
           ex_multicycle_start, ex_multicycle_cycles,
    input  stall, bubble, ex_multicycle_done, ex_busy
  );

  // Controller side.
  modport slave (
    input  if_stall_request, id_stall_request, mem_stall_request, flush_request,
           ex_multicycle_start, ex_multicycle_cycles,
    output stall, bubble, ex_multicycle_done, ex_busy
  );

endinterface

// File: rtl/pipeline_stall_controller_ex_multicycle_sequencer.sv
// Multi-cycle EX sequencer (mult/div into HI/LO): holds EX for max(N,1)+1
// cycles from the start cycle, then presents done until MEM lets ex_mem move.
// Optional feature macro (handled in the top): PIPELINE_STALL_COUNTER_EN.
//
//   state | meaning
//   IDLE  | no op in flight; a start stalls EX in its own cycle
//   BUSY  | op executing; EX held while the down-counter runs to 0
//   DONE  | result valid, HI/LO write allowed; held while MEM stalls
module ex_multicycle_sequencer
  import pipeline_stall_controller_pkg::*;
#(
  parameter int CYCLE_WIDTH = 6
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CYCLE_WIDTH-1:0] cycles,
  input  logic                   flush,
  input  logic                   mem_hold,
  output logic                   ex_stall_request,
  output logic                   done,
  output logic                   busy
);

  localparam logic [CYCLE_WIDTH-1:0] CNT_ONE = CYCLE_WIDTH'(1);

  seq_state_e             state_q, state_d;
  logic [CYCLE_WIDTH-1:0] count_q, count_d;

  // State and down-counter registers.
  always_ff @(posedge clock) begin
    if (reset == RESET_ENABLE) begin
      state_q <= SEQ_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next state, counter load/decrement and sequencer outputs.
  always_comb begin
    state_d          = state_q;
    count_d          = count_q;
    ex_stall_request = 1'b0;
    done             = 1'b0;
    busy             = (state_q != SEQ_IDLE);

    unique case (state_q)
      SEQ_IDLE: begin
        ex_stall_request = start;
        if (start) begin
          state_d = SEQ_BUSY;
          // N=0 is treated as a single-cycle op.
          count_d = (cycles == '0) ? '0 : (cycles - CNT_ONE);
        end
      end
      SEQ_BUSY: begin
        ex_stall_request = 1'b1;
        if (count_q == '0) begin
          state_d = SEQ_DONE;
        end else begin
          count_d = count_q - CNT_ONE;
        end
      end
      SEQ_DONE: begin
        done = 1'b1;
        // ex_mem cannot take the result yet; keep it presented.
        if (!mem_hold) begin
          state_d = SEQ_IDLE;
        end
      end
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase

    if (flush) begin
      state_d = SEQ_IDLE;
      count_d = '0;
      done    = 1'b0;
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall controller top: merges per-stage stall requests, the
// multi-cycle EX sequencer and flush into per-latch hold/bubble vectors.
// Optional feature macro: PIPELINE_STALL_COUNTER_EN adds a saturating
// count of cycles in which the pc latch was held (stall_cycle_count).
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int CYCLE_WIDTH = 6
`ifdef PIPELINE_STALL_COUNTER_EN
  , parameter int STAT_WIDTH = 32
`endif
) (
  input  logic                      clock,
  input  logic                      reset,
  pipeline_stall_controller_if.slave bus
`ifdef PIPELINE_STALL_COUNTER_EN
  , output logic [STAT_WIDTH-1:0]   stall_cycle_count
`endif
);

  logic       seq_ex_stall;
  logic       seq_done;
  logic       seq_busy;
  logic [2:0] depth;
  latch_vec_t stall_vec;
  latch_vec_t bubble_vec;
  logic       done_out;
  logic       busy_out;

  ex_multicycle_sequencer #(
    .CYCLE_WIDTH(CYCLE_WIDTH)
  ) u_seq (
    .clock            (clock),
    .reset            (reset),
    .start            (bus.ex_multicycle_start),
    .cycles           (bus.ex_multicycle_cycles),
    .flush            (bus.flush_request),
    .mem_hold         (bus.mem_stall_request),
    .ex_stall_request (seq_ex_stall),
    .done             (seq_done),
    .busy             (seq_busy)
  );

  // Highest stalled stage wins; flush overrides it; reset silences everything.
  always_comb begin
    depth = 3'd0;
    if (bus.mem_stall_request) begin
      depth = 3'(STAGE_MEM + 1);
    end else if (seq_ex_stall) begin
      depth = 3'(STAGE_EX + 1);
    end else if (bus.id_stall_request) begin
      depth = 3'(STAGE_ID + 1);
    end else if (bus.if_stall_request) begin
      depth = 3'(STAGE_IF + 1);
    end

    stall_vec  = stall_mask(depth);
    bubble_vec = bubble_mask(depth);
    done_out   = seq_done;
    busy_out   = seq_busy;

    if (bus.flush_request) begin
      stall_vec  = '0;
      bubble_vec = FLUSH_BUBBLE;
    end

    if (reset == RESET_ENABLE) begin
      stall_vec  = '0;
      bubble_vec = '0;
      done_out   = 1'b0;
      busy_out   = 1'b0;
    end
  end

  assign bus.stall              = stall_vec;
  assign bus.bubble             = bubble_vec;
  assign bus.ex_multicycle_done = done_out;
  assign bus.ex_busy            = busy_out;

`ifdef PIPELINE_STALL_COUNTER_EN
  localparam logic [STAT_WIDTH-1:0] STAT_ONE = STAT_WIDTH'(1);

  logic [STAT_WIDTH-1:0] stat_q, stat_d;

  // Count pc-held cycles, excluding flush cycles; stick at all-ones.
  always_comb begin
    stat_d = stat_q;
    if (stall_vec[0] && !bus.flush_request && !(&stat_q)) begin
      stat_d = stat_q + STAT_ONE;
    end
  end

  // Stall statistics register.
  always_ff @(posedge clock) begin
    if (reset == RESET_ENABLE) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stall_cycle_count = stat_q;
`endif

endmodule
